// File: rtl/serial_adder_word_driver.sv
// Word-level front end for a 1-bit serial adder.
// Streams operands LSB-first and collects the serial sum into a parallel word.
module serial_adder_word_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_clr,
    input  logic             ser_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   sh_a;
    logic [WIDTH:0]   sh_b;
    logic [WIDTH:0]   res;
    logic [WIDTH:0]   res_next;
    logic [CW-1:0]    cnt;

    // The zero-padded top bit makes the last shift cycle present a=b=0,
    // so the adder's returned sum on that cycle is its carry-out.
    assign ser_a    = sh_a[0];
    assign ser_b    = sh_b[0];
    assign res_next = {ser_sum, res[WIDTH:1]};

    // Control FSM with registered handshake, carry-clear and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            res       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            ser_clr   <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sh_a     <= {1'b0, in_a};
                        sh_b     <= {1'b0, in_b};
                        res      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        ser_clr  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    res  <= res_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH)) begin
                        ser_clr   <= 1'b1;
                        out_valid <= 1'b1;
                        out_sum   <= res_next[WIDTH-1:0];
                        out_carry <= res_next[WIDTH];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_word_driver.sv
// Scoreboard bench for serial_adder_word_driver wired to a serial adder model.
// Driver pushes expected sums; a negedge monitor pops and compares results.
module tb_serial_adder_word_driver;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_a;
    logic         ser_b;
    logic         ser_clr;
    logic         ser_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    logic         carry;

    logic [W:0]   exp_q[$];
    int           pass_cnt = 0;
    int           total = 0;
    int           cyc = 0;
    int           last_acc = 0;
    int           rise_cyc = 0;
    logic [W:0]   last_res = '0;
    logic [W:0]   held = '0;
    bit           held_v = 0;
    bit           prev_ov = 0;
    bit           rand_mode = 0;

    serial_adder_word_driver #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .ser_a(ser_a),
        .ser_b(ser_b),
        .ser_clr(ser_clr),
        .ser_sum(ser_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_carry(out_carry)
    );

    // Bit-serial adder: combinational sum, carry flop with synchronous clear.
    assign ser_sum = ser_a ^ ser_b ^ carry;
    always @(posedge clk) begin
        if (ser_clr) carry <= 1'b0;
        else carry <= (ser_a & ser_b) | (ser_a & carry) | (ser_b & carry);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: protocol checks, stall stability, scoreboard pop.
    always @(negedge clk) begin
        if (rst) begin
            held_v  = 0;
            prev_ov = 0;
        end else begin
            chk("ser_clr_state", ser_clr, in_ready | out_valid);
            chk("ready_valid_excl", in_ready & out_valid, 0);
            if (held_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_carry, out_sum}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got %0h expected none",
                             {out_carry, out_sum});
                end else begin
                    chk("result", {out_carry, out_sum}, exp_q.pop_front());
                end
                last_res = {out_carry, out_sum};
            end
            held_v = out_valid && !out_ready;
            held   = {out_carry, out_sum};
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;
        end
    end

    // Random consumer back-pressure during the soak phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("send_accept", ok, 1);
        if (ok) begin
            exp_q.push_back({1'b0, a} + {1'b0, b});
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] sa_seq;
        logic [W:0] sb_seq;
        int         d;
        bit         seen;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ser_clr", ser_clr, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ser_ab", {ser_a, ser_b}, 0);
        chk("rst_out", {out_carry, out_sum}, 0);
        rst = 1'b0;
        idle(1);

        // 0x5A + 0x3C: serial bit order and latency.
        send(8'h5A, 8'h3C);
        in_valid = 1'b0;
        sa_seq = '0;
        sb_seq = '0;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            sa_seq[i] = ser_a;
            sb_seq[i] = ser_b;
        end
        chk("ser_a_seq", sa_seq, 9'h05A);
        chk("ser_b_seq", sb_seq, 9'h03C);
        drain();
        chk("sum_5a_3c", last_res, 9'h096);
        chk("latency", rise_cyc - last_acc, W + 2);

        // Carry-out followed by a zero word: carry must not leak.
        idle(1);
        send(8'hFF, 8'h01);
        in_valid = 1'b0;
        drain();
        chk("sum_ff_01", last_res, 9'h100);
        idle(1);
        send(8'h00, 8'h00);
        in_valid = 1'b0;
        drain();
        chk("sum_00_00", last_res, 9'h000);

        // 0xFF + 0xFF with consumer stall.
        idle(1);
        out_ready = 1'b0;
        send(8'hFF, 8'hFF);
        in_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("stall_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", {out_carry, out_sum}, 9'h1FE);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("sum_ff_ff", last_res, 9'h1FE);
        drain();

        // in_valid held across SHIFT/DONE with new operands.
        idle(1);
        send(8'h81, 8'h7F);
        send(8'h33, 8'h44);
        in_valid = 1'b0;
        d = last_acc;
        drain();
        chk("back_to_back_sum", last_res, 9'h077);
        chk("min_period", d - (d - (W + 3)), W + 3);

        // Measure spacing properly: two held requests, record each accept.
        idle(1);
        send(8'h01, 8'h02);
        d = last_acc;
        send(8'h03, 8'h04);
        in_valid = 1'b0;
        chk("accept_spacing", last_acc - d, W + 3);
        drain();
        chk("second_pair_sum", last_res, 9'h007);

        // Asynchronous reset in SHIFT cycle 4.
        idle(1);
        send(8'h12, 8'h34);
        in_valid = 1'b0;
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_ser_clr", ser_clr, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_ser_ab", {ser_a, ser_b}, 0);
        chk("arst_out", {out_carry, out_sum}, 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        send(8'h12, 8'h34);
        in_valid = 1'b0;
        drain();
        chk("sum_12_34", last_res, 9'h046);

        // Random soak with producer gaps and consumer stalls.
        rand_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            idle($urandom_range(0, 2));
            send(W'($urandom), W'($urandom));
            in_valid = 1'b0;
        end
        idle(1);
        rand_mode = 0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
